// File: rtl/chan_mux_rr.sv
// chan_mux_rr: registered N-channel mux with valid/ready handshakes,
// selectable address or round-robin arbitration and a source-channel tag.
module chan_mux_rr #(
    parameter int WIDTH      = 8,
    parameter int ADDR_WIDTH = 2
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               mode,
    input  logic [ADDR_WIDTH-1:0]              address,
    input  logic [(2**ADDR_WIDTH)*WIDTH-1:0]   in_data,
    input  logic [(2**ADDR_WIDTH)-1:0]         in_valid,
    output logic [(2**ADDR_WIDTH)-1:0]         in_ready,
    output logic [WIDTH-1:0]                   out_data,
    output logic [ADDR_WIDTH-1:0]              out_channel,
    output logic                               out_valid,
    input  logic                               out_ready
);
    localparam int CH = 2**ADDR_WIDTH;

    logic [ADDR_WIDTH-1:0] ptr;
    logic [ADDR_WIDTH-1:0] rr_idx;
    logic [ADDR_WIDTH-1:0] cand;
    logic [ADDR_WIDTH-1:0] gidx;
    logic                  rr_hit;
    logic                  grant;
    logic                  load_en;
    logic [CH-1:0]         one_hot;

    assign load_en = !out_valid || out_ready;

    // Walk downward so the channel closest after ptr wins; k = CH wraps to ptr.
    always_comb begin
        rr_idx = '0;
        rr_hit = 1'b0;
        cand   = '0;
        for (int k = CH; k >= 1; k--) begin
            cand = ptr + k[ADDR_WIDTH-1:0];
            if (in_valid[cand]) begin
                rr_idx = cand;
                rr_hit = 1'b1;
            end
        end
    end

    always_comb begin
        gidx  = mode ? rr_idx : address;
        grant = mode ? rr_hit : in_valid[address];
    end

    always_comb begin
        one_hot = '0;
        one_hot[gidx] = 1'b1;
        in_ready = (load_en && grant && !reset) ? one_hot : '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_channel <= '0;
            ptr         <= ADDR_WIDTH'(CH - 1);
        end else if (load_en) begin
            if (grant) begin
                out_valid   <= 1'b1;
                out_data    <= in_data[gidx*WIDTH +: WIDTH];
                out_channel <= gidx;
                ptr         <= gidx;
            end else begin
                out_valid   <= 1'b0;
            end
        end
    end
endmodule

// File: doc/chan_mux_rr.md
# chan_mux_rr

Registered N-channel, WIDTH-bit multiplexer with per-channel valid/ready handshakes and two selection modes: explicit address select, or round-robin arbitration among requesting channels. It generalises the 4:1 single-bit select into a pipelined datapath stage that merges several producer streams into one consumer stream. Each transfer carries a channel tag so downstream logic knows the source.

## Interface
- WIDTH, 8, data bits per channel (≥1)
- ADDR_WIDTH, 2, select width; CHANNELS = 2**ADDR_WIDTH (1..4, i.e. 2..16 channels)
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  asynchronous, active-high; clears all state immediately
- mode  input  1  0 = address mode, 1 = round-robin mode
- address  input  ADDR_WIDTH  channel select in address mode; ignored in round-robin mode
- in_data  input  CHANNELS*WIDTH  flattened inputs; channel i at bits [i*WIDTH +: WIDTH]
- in_valid  input  CHANNELS  per-channel request
- in_ready  output  CHANNELS  per-channel accept; at most one bit high per cycle
- out_data  output  WIDTH  registered selected data
- out_channel  output  ADDR_WIDTH  registered source channel of out_data
- out_valid  output  1  output register holds a word
- out_ready  input  1  consumer accepts

## Operation
- Single output register (data, channel, valid). load_en = !out_valid | out_ready.
- Grant selection (combinational):
  - Address mode: grant = address if in_valid[address]; else no grant. Other channels never granted.
  - Round-robin mode: search channels ptr+1, ptr+2, … wrapping modulo CHANNELS, ending at ptr; first with in_valid high is granted.
- in_ready[g] = load_en & grant exists; all other in_ready bits 0. Transfer on channel g when in_valid[g] & in_ready[g].
- On transfer: out_data ← in_data[g], out_channel ← g, out_valid ← 1.
- If load_en and no grant: out_valid ← 0 (out_data/out_channel hold their old value).
- If !load_en (out_valid & !out_ready): register holds all fields; all in_ready 0.
- Round-robin pointer ptr (ADDR_WIDTH bits): updated to g on every transfer in either mode, so the round-robin search after a mode switch starts after the last served channel. Not updated without a transfer.
- Mode or address changes take effect on the same cycle's grant; no transfer in flight is affected.
- Reset values: out_valid 0, out_data 0, out_channel 0, ptr = CHANNELS-1 (first round-robin search starts at channel 0); in_ready all 0 while reset is high.
- Reset asserted mid-stream drops the held word; no transfer is reported on the reset cycle.

## Timing
- Latency: 1 cycle from accepted input to out_valid/out_data.
- Throughput: one word per cycle while out_ready is high and a grant exists.
- in_ready is combinational from out_ready, out_valid, in_valid, mode, address and ptr; no combinational path from any input to out_data/out_valid.
- Producers must hold in_data/in_valid stable until accepted; consumer sees out_data stable while out_valid & !out_ready.
- Round-robin fairness: with all channels continuously valid and out_ready high, each channel is served exactly once every CHANNELS cycles.

## Test plan
- Reset: assert reset asynchronously mid-cycle with out_valid=1 -> out_valid, out_data, out_channel drop to 0 before next edge; after release, first round-robin grant with all valid is channel 0.
- Address mode, WIDTH=8, CHANNELS=4: in_data = {8'h44,8'h33,8'h22,8'h11}, all valid, address=2, out_ready=1 -> next cycle out_data=8'h33, out_channel=2; in_ready=4'b0100; address=1 with in_valid[1]=0 -> no transfer, out_valid falls to 0.
- Round-robin, all valid, out_ready=1 for 8 cycles -> out_channel sequence 0,1,2,3,0,1,2,3, one word per cycle.
- Round-robin with in_valid=4'b1001 after serving channel 0 -> next grant 3, then 0, then 3; channels 1,2 never granted.
- Backpressure: out_valid=1, out_ready=0 for 3 cycles while inputs change -> out_data/out_channel unchanged, in_ready=0, ptr unchanged; out_ready=1 -> held word consumed and new word loaded on the same edge.
- Mode switch: address mode serves channel 2, then mode=1 with all valid -> next grant channel 3, then 0.
